// File: rtl/spi_pkg.sv
// Shared FSM state encoding, command codes and the command/state agreement check
// for the parametrised SPI slave.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        CHK_CMD   = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4,
        WAIT_TX   = 3'd5,
        SEND      = 3'd6,
        DONE      = 3'd7
    } state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // The path picked in CHK_CMD must agree with the command bits that arrive later.
    function automatic logic cmd_ok(input state_e s, input logic [1:0] cmd);
        case (s)
            WRITE:     cmd_ok = (cmd == CMD_WR_ADDR) || (cmd == CMD_WR_DATA);
            READ_ADD:  cmd_ok = (cmd == CMD_RD_ADDR);
            READ_DATA: cmd_ok = (cmd == CMD_RD_DATA);
            default:   cmd_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-in serial-out shifter driving MISO MSB first; the first bit leaves on the
// load edge so the payload occupies exactly PAYLOAD_W cycles of SEND.
module spi_tx_shifter
    import spi_pkg::*;
#(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 shift_i,
    input  logic                 clr_i,
    input  logic [PAYLOAD_W-1:0] data_i,
    output logic                 miso_o,
    output logic                 done_o
);

    localparam int CW = $clog2(PAYLOAD_W + 1);

    logic [PAYLOAD_W-1:0] tx_q, tx_d;
    logic                 miso_q, miso_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    assign done_o = (cnt_q == CW'(PAYLOAD_W));
    assign miso_o = miso_q;

    always_comb begin
        tx_d   = tx_q;
        miso_d = miso_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            tx_d   = {data_i[PAYLOAD_W-2:0], 1'b0};
            miso_d = data_i[PAYLOAD_W-1];
            cnt_d  = CW'(1);
        end else if (shift_i) begin
            if (done_o) begin
                miso_d = 1'b0;
            end else begin
                miso_d = tx_q[PAYLOAD_W-1];
                tx_d   = {tx_q[PAYLOAD_W-2:0], 1'b0};
                cnt_d  = cnt_q + 1'b1;
            end
        end else if (clr_i) begin
            miso_d = 1'b0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q   <= '0;
            miso_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            tx_q   <= tx_d;
            miso_q <= miso_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front-end: receives {cmd, payload} frames on MOSI, tracks the
// read-address/read-data sequence and returns read data on MISO after a TX handshake.
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int PAYLOAD_W  = 8,
    parameter int TX_TIMEOUT = 16,
    parameter int CNT_W      = $clog2(PAYLOAD_W + 2 + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   SS_n,
    input  logic                   MOSI,
    input  logic                   tx_valid,
    input  logic [PAYLOAD_W-1:0]   tx_data,
    output logic                   rx_valid,
    output logic [PAYLOAD_W+1:0]   rx_data,
    output logic                   tx_ready,
    output logic                   MISO,
    output logic                   frame_err,
    output logic                   busy,
    output logic [2:0]             cs_dbg
);

    localparam int FRAME_W = PAYLOAD_W + 2;
    localparam int TIMER_W = $clog2(TX_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   LAST_CNT     = CNT_W'(FRAME_W - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TX_TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 addr_seen_q, addr_seen_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 tx_load, tx_shift, tx_clr, tx_done;
    logic [FRAME_W-1:0]   rx_shift;
    logic [1:0]           cmd;

    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign tx_ready  = tx_ready_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);
    assign cs_dbg    = state_q;

    // SS_n high is checked first in every active state so a deselect always wins.
    always_comb begin
        state_d     = state_q;
        rx_data_d   = rx_data_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        addr_seen_d = addr_seen_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        tx_ready_d  = 1'b0;
        tx_load     = 1'b0;
        tx_shift    = 1'b0;
        tx_clr      = 1'b0;
        rx_shift    = {rx_data_q[FRAME_W-2:0], MOSI};
        cmd         = rx_shift[FRAME_W-1 -: 2];

        unique case (state_q)
            IDLE: begin
                if (!SS_n) begin
                    state_d   = CHK_CMD;
                    rx_data_d = '0;
                    cnt_d     = '0;
                end
            end
            CHK_CMD: begin
                if (SS_n) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (!MOSI) begin
                    state_d = WRITE;
                end else if (addr_seen_q) begin
                    state_d = READ_DATA;
                end else begin
                    state_d = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    rx_data_d = rx_shift;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d      = CNT_W'(FRAME_W);
                        rx_valid_d = 1'b1;
                        if (cmd_ok(state_q, cmd)) begin
                            if (state_q == READ_ADD)  addr_seen_d = 1'b1;
                            if (state_q == READ_DATA) addr_seen_d = 1'b0;
                            state_d = (state_q == READ_DATA) ? WAIT_TX : DONE;
                            timer_d = '0;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WAIT_TX: begin
                if (SS_n) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (tx_valid) begin
                    tx_load    = 1'b1;
                    tx_ready_d = 1'b1;
                    state_d    = SEND;
                end else if (timer_q == TIMEOUT_LAST) begin
                    frame_err_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            SEND: begin
                if (SS_n) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    tx_clr      = 1'b1;
                end else begin
                    tx_shift = 1'b1;
                    if (tx_done) state_d = DONE;
                end
            end
            DONE: begin
                if (SS_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rx_data_q   <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            addr_seen_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            tx_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_data_q   <= rx_data_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            addr_seen_q <= addr_seen_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            tx_ready_q  <= tx_ready_d;
        end
    end

    spi_tx_shifter #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_tx_shifter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (tx_load),
        .shift_i (tx_shift),
        .clr_i   (tx_clr),
        .data_i  (tx_data),
        .miso_o  (MISO),
        .done_o  (tx_done)
    );

endmodule
